// File: rtl/pwm_pulse_decoder.sv
// -----------------------------------------------------------------------------
// pwm_pulse_decoder
//   Receive side of the servo-style PWM link. Measures the high time of each
//   incoming pulse in prescaled ticks and turns it into a 2-bit drive
//   instruction (10 back, 11 stop, 01 forward). Malformed pulses (too short or
//   too long) and loss of signal force the instruction back to stop.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   pwm_in   in   asynchronous PWM pin
//   instr    out  [1:0] decoded instruction
//   valid    out  one-clk pulse when instr is updated from a legal pulse
//   err      out  one-clk pulse when a pulse is rejected
//   timeout  out  level, high while the signal is lost
//   width    out  [11:0] last measured pulse width in ticks
// -----------------------------------------------------------------------------
module pwm_pulse_decoder #(
    parameter int CLK_DIV   = 256,
    parameter int MIN_W     = 100,
    parameter int TH_BS     = 192,
    parameter int TH_SF     = 269,
    parameter int MAX_W     = 400,
    parameter int PERIOD_TO = 4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [1:0]  instr,
    output logic        valid,
    output logic        err,
    output logic        timeout,
    output logic [11:0] width
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] ST_WAIT_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] ST_MEASURE   = 2'd2;
    localparam logic [1:0] ST_DECIDE    = 2'd3;

    localparam logic [1:0] INSTR_BACK = 2'b10;
    localparam logic [1:0] INSTR_STOP = 2'b11;
    localparam logic [1:0] INSTR_FWD  = 2'b01;

    localparam logic [11:0] MIN_W_C   = 12'(MIN_W);
    localparam logic [11:0] TH_BS_C   = 12'(TH_BS);
    localparam logic [11:0] TH_SF_C   = 12'(TH_SF);
    localparam logic [11:0] MAX_W_C   = 12'(MAX_W);
    localparam logic [11:0] MAX_OVF_C = 12'(MAX_W + 1);
    localparam logic [11:0] PER_TO_C  = 12'(PERIOD_TO);
    localparam logic [11:0] SAT_C     = 12'hFFF;

    // ------------------------------------------------------------------
    // Input conditioning. The chain resets to 1 so that a pin already high
    // when reset releases never looks like a rising edge; the FSM only arms
    // after a genuine low has been observed.
    // ------------------------------------------------------------------
    logic sync_meta_q, s_q, s_dly_q;
    logic rise, fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_q <= 1'b1;
            s_q         <= 1'b1;
            s_dly_q     <= 1'b1;
        end else begin
            sync_meta_q <= pwm_in;
            s_q         <= sync_meta_q;
            s_dly_q     <= s_q;
        end
    end

    assign rise = s_q & ~s_dly_q;
    assign fall = ~s_q & s_dly_q;

    // ------------------------------------------------------------------
    // Free-running tick prescaler (never realigned to pulse edges)
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    assign tick = (pre_q == PW'(CLK_DIV - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Measurement FSM, period watchdog and output registers
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [11:0] wcnt_q, wcnt_d;
    logic [11:0] pcnt_q, pcnt_d;
    logic [1:0]  instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;
    logic [11:0] width_q, width_d;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        pcnt_d    = pcnt_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        timeout_d = timeout_q;
        width_d   = width_q;

        // Watchdog first so that the FSM below can override it. A rise in the
        // same cycle as the expiry clears the counter and suppresses timeout.
        if (rise) begin
            pcnt_d = '0;
        end else if (tick && (pcnt_q != PER_TO_C)) begin
            pcnt_d = pcnt_q + 12'd1;
            if (pcnt_q == PER_TO_C - 12'd1) begin
                timeout_d = 1'b1;
                instr_d   = INSTR_STOP;
            end
        end

        case (state_q)
            ST_WAIT_LOW: begin
                if (!s_q) begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    wcnt_d  = '0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // The tick of the fall cycle is counted before DECIDE compares.
                if (tick && (wcnt_q != SAT_C)) begin
                    wcnt_d = wcnt_q + 12'd1;
                end
                if (fall) begin
                    state_d = ST_DECIDE;
                end else if (wcnt_d == MAX_OVF_C) begin
                    err_d   = 1'b1;
                    instr_d = INSTR_STOP;
                    width_d = MAX_OVF_C;
                    state_d = ST_WAIT_LOW;
                end
            end
            default: begin // ST_DECIDE
                width_d = wcnt_q;
                state_d = ST_WAIT_RISE;
                if ((wcnt_q < MIN_W_C) || (wcnt_q > MAX_W_C)) begin
                    err_d = 1'b1;
                end else begin
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    if (wcnt_q < TH_BS_C) begin
                        instr_d = INSTR_BACK;
                    end else if (wcnt_q < TH_SF_C) begin
                        instr_d = INSTR_STOP;
                    end else begin
                        instr_d = INSTR_FWD;
                    end
                end
                // A one-clk low gap would otherwise lose the next rise.
                if (rise) begin
                    wcnt_d  = '0;
                    state_d = ST_MEASURE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            state_q   <= ST_WAIT_LOW;
            wcnt_q    <= '0;
            pcnt_q    <= '0;
            instr_q   <= INSTR_STOP;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            width_q   <= '0;
        end else begin
            pre_q     <= pre_d;
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            pcnt_q    <= pcnt_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            width_q   <= width_d;
        end
    end

    assign instr   = instr_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign timeout = timeout_q;
    assign width   = width_q;

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_pulse_decoder
//   Scoreboard bench: stimulus pushes the expected event for each pulse into a
//   queue; a monitor pops and compares whenever the DUT raises valid, err or a
//   new timeout. Pulses are driven as whole numbers of ticks (CLK_DIV=4).
// -----------------------------------------------------------------------------
module tb_pwm_pulse_decoder;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 50;

    localparam int K_VALID = 0;
    localparam int K_ERR   = 1;
    localparam int K_TO    = 2;

    typedef struct {
        int          kind;
        logic [1:0]  instr;
        logic [11:0] width;
        bit          lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        pwm_in;
    logic [1:0]  instr;
    logic        valid;
    logic        err;
    logic        timeout;
    logic [11:0] width;

    pwm_pulse_decoder #(
        .CLK_DIV   (CLK_DIV),
        .MIN_W     (100),
        .TH_BS     (192),
        .TH_SF     (269),
        .MAX_W     (400),
        .PERIOD_TO (4000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pwm_in  (pwm_in),
        .instr   (instr),
        .valid   (valid),
        .err     (err),
        .timeout (timeout),
        .width   (width)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   last_fall_cyc = 0;
    int   rst_chk_req = 0;
    int   rst_chk_done = 0;
    bit   final_req = 1'b0;
    bit   final_done = 1'b0;
    logic timeout_prev = 1'b0;

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        int   got_kind;
        if (!reset) begin
            if (rst_chk_req != rst_chk_done) begin
                rst_chk_done = rst_chk_req;
                total++; if (instr !== 2'b11) begin bad++; $display("FAIL rst_instr got=%b want=11", instr); end
                total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid); end
                total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
                total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout); end
                total++; if (width !== 12'd0) begin bad++; $display("FAIL rst_width got=%0d want=0", width); end
                $display("reset check: instr=%b valid=%b err=%b timeout=%b width=%0d", instr, valid, err, timeout, width);
            end

            if (valid || err || (timeout && !timeout_prev)) begin
                got_kind = valid ? K_VALID : (err ? K_ERR : K_TO);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event kind=%0d instr=%b width=%0d want=no_event", got_kind, instr, width);
                end else begin
                    e = exp_q.pop_front();
                    if (got_kind != e.kind) begin
                        bad++;
                        $display("FAIL event_kind got=%0d want=%0d", got_kind, e.kind);
                    end
                    total++;
                    if (instr !== e.instr) begin
                        bad++;
                        $display("FAIL instr got=%b want=%b", instr, e.instr);
                    end
                    if (e.kind != K_TO) begin
                        total++;
                        if (width !== e.width) begin
                            bad++;
                            $display("FAIL width got=%0d want=%0d", width, e.width);
                        end
                    end
                    if (e.kind == K_VALID) begin
                        total++;
                        if (timeout !== 1'b0) begin
                            bad++;
                            $display("FAIL timeout_clear got=%b want=0", timeout);
                        end
                    end
                    if (e.lat) begin
                        total++;
                        if ((cyc - last_fall_cyc) > 5) begin
                            bad++;
                            $display("FAIL latency got=%0d want<=5", cyc - last_fall_cyc);
                        end
                    end
                    $display("event kind=%0d instr=%b width=%0d timeout=%b lat=%0d", got_kind, instr, width, timeout, cyc - last_fall_cyc);
                end
            end

            if (final_req && !final_done) begin
                final_done = 1'b1;
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL missing_events got_pending=%0d want=0", exp_q.size());
                end
            end
        end
        timeout_prev = timeout;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic expect_ev(input int kind, input logic [1:0] ins, input int w, input bit lat);
        exp_t e;
        e.kind  = kind;
        e.instr = ins;
        e.width = 12'(w);
        e.lat   = lat;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int hi_ticks, input int lo_ticks);
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (hi_ticks * CLK_DIV) @(posedge clk);
        #1 pwm_in = 1'b0;
        last_fall_cyc = cyc;
        repeat (lo_ticks * CLK_DIV) @(posedge clk);
    endtask

    int         hi_tab[11]  = '{154, 230, 307, 191, 192, 268, 269, 99, 100, 450, 307};
    int         kind_tab[11] = '{K_VALID, K_VALID, K_VALID, K_VALID, K_VALID, K_VALID, K_VALID,
                                 K_ERR, K_VALID, K_ERR, K_VALID};
    logic [1:0] ins_tab[11] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01,
                                2'b01, 2'b10, 2'b11, 2'b01};
    int         w_tab[11]   = '{154, 230, 307, 191, 192, 268, 269, 99, 100, 401, 307};

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rst_chk_req = rst_chk_req + 1;
        repeat (20) @(posedge clk);

        // Decode, boundaries, short pulse, stuck-high overflow
        for (int i = 0; i < 11; i++) begin
            expect_ev(kind_tab[i], ins_tab[i], w_tab[i], (hi_tab[i] != 450));
            pulse(hi_tab[i], GAP);
        end

        // Loss of signal: stays low well past the watchdog limit
        expect_ev(K_TO, 2'b11, 0, 1'b0);
        repeat (4000 * CLK_DIV) @(posedge clk);
        expect_ev(K_VALID, 2'b10, 154, 1'b1);
        pulse(154, GAP);

        // Reset while the pin is high: the stale pulse is never measured
        @(posedge clk); #1 reset = 1'b1;
        pwm_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rst_chk_req = rst_chk_req + 1;
        repeat (200 * CLK_DIV) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (GAP * CLK_DIV) @(posedge clk);
        expect_ev(K_VALID, 2'b11, 230, 1'b1);
        pulse(230, GAP);

        @(posedge clk); #1 final_req = 1'b1;
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
